bank_write_arbiter: RTL and testbench

BANK_WRITE_ARBITER -- requirements
Module: bank_write_arbiter

---
 rtl/bank_arb_pkg.sv | 14 +
 rtl/bank_arb_slice.sv | 113 +++++++++++
 rtl/bank_write_arbiter.sv | 168 ++++++++++++++++
 tb/tb_bank_write_arbiter.sv | 510 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bank_arb_pkg.sv
// Shared definitions for the bank write arbiter.
//   arb_state_e : control FSM state (run, drain, done)
//   STARVE_W    : width of each per-bank starvation counter
package bank_arb_pkg;

    localparam int unsigned STARVE_W = 4;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/bank_arb_slice.sv
// Single-bank grant, starvation tracking and registered bank write port.
// Ports:
//   clk, reset_n        : clock, asynchronous active-low reset
//   enable_i            : grants allowed this cycle (low right after reset release)
//   local_block_i       : drain/done in progress; local loses, neighbor always wins
//   local_* / neighbor_*: the two competing write requests for this bank
//   local_ready_o       : local request accepted this cycle
//   neighbor_ready_o    : neighbor request accepted this cycle
//   buf_*_o             : registered write port, one cycle after acceptance
module bank_arb_slice
    import bank_arb_pkg::*;
#(
    parameter int unsigned ROW_W        = 7,
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable_i,
    input  logic                  local_block_i,
    input  logic [ROW_W-1:0]      local_row_i,
    input  logic [ROW_W-1:0]      local_column_i,
    input  logic [DATA_WIDTH-1:0] local_data_i,
    input  logic                  local_valid_i,
    input  logic [ROW_W-1:0]      neighbor_row_i,
    input  logic [ROW_W-1:0]      neighbor_column_i,
    input  logic [DATA_WIDTH-1:0] neighbor_data_i,
    input  logic                  neighbor_valid_i,
    output logic                  local_ready_o,
    output logic                  neighbor_ready_o,
    output logic [ROW_W-1:0]      buf_row_o,
    output logic [ROW_W-1:0]      buf_column_o,
    output logic [DATA_WIDTH-1:0] buf_data_o,
    output logic                  buf_we_o
);

    logic [STARVE_W-1:0]   starve_q, starve_d;
    logic [ROW_W-1:0]      row_q, row_d;
    logic [ROW_W-1:0]      col_q, col_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  we_q, we_d;
    logic                  starved;
    logic                  local_grant;
    logic                  neighbor_grant;

    assign starved = (starve_q == STARVE_W'(STARVE_LIMIT));

    // Neighbor wins when it is alone, when local traffic is blocked, or when it has
    // lost STARVE_LIMIT times in a row; otherwise local has priority.
    always_comb begin
        local_grant    = 1'b0;
        neighbor_grant = 1'b0;
        if (enable_i) begin
            if (neighbor_valid_i && (local_block_i || starved || !local_valid_i)) begin
                neighbor_grant = 1'b1;
            end else if (local_valid_i && !local_block_i) begin
                local_grant = 1'b1;
            end
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (enable_i) begin
            if (neighbor_grant) begin
                starve_d = '0;
            end else if (neighbor_valid_i && !starved) begin
                starve_d = starve_q + STARVE_W'(1);
            end
        end
    end

    // Address/data hold their last written value when the bank is idle.
    always_comb begin
        we_d   = local_grant | neighbor_grant;
        row_d  = row_q;
        col_d  = col_q;
        data_d = data_q;
        if (neighbor_grant) begin
            row_d  = neighbor_row_i;
            col_d  = neighbor_column_i;
            data_d = neighbor_data_i;
        end else if (local_grant) begin
            row_d  = local_row_i;
            col_d  = local_column_i;
            data_d = local_data_i;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_q <= '0;
            row_q    <= '0;
            col_q    <= '0;
            data_q   <= '0;
            we_q     <= 1'b0;
        end else begin
            starve_q <= starve_d;
            row_q    <= row_d;
            col_q    <= col_d;
            data_q   <= data_d;
            we_q     <= we_d;
        end
    end

    assign local_ready_o    = local_grant;
    assign neighbor_ready_o = neighbor_grant;
    assign buf_row_o        = row_q;
    assign buf_column_o     = col_q;
    assign buf_data_o       = data_q;
    assign buf_we_o         = we_q;

endmodule

// File: rtl/bank_write_arbiter.sv
// Per-bank write arbiter between local crossbar traffic and neighbor processor
// traffic, with a drain FSM that blocks local writes and flushes neighbor writes.
// Ports:
//   clk, reset_n                 : clock, asynchronous active-low reset
//   local_* / local_ready        : local write requests and per-bank accept
//   neighbor_* / neighbor_ready  : neighbor write requests and per-bank accept
//   buffer_*_write, buffer_write_enable : registered per-bank write ports
//   drain_req / drain_done       : drain handshake
//   neighbor_pending             : some neighbor request is waiting
//   conflict_count               : saturating count of cycles with any bank in
//                                  conflict; present only with the macro
//                                  BANK_WRITE_ARBITER_STATS_EN defined
module bank_write_arbiter
    import bank_arb_pkg::*;
#(
    parameter int unsigned BANK_COUNT   = 32,
    parameter int unsigned TILE_SIZE    = 128,
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [$clog2(TILE_SIZE)-1:0]   local_row           [BANK_COUNT],
    input  logic [$clog2(TILE_SIZE)-1:0]   local_column        [BANK_COUNT],
    input  logic [DATA_WIDTH-1:0]          local_data          [BANK_COUNT],
    input  logic                           local_valid         [BANK_COUNT],
    output logic                           local_ready         [BANK_COUNT],
    input  logic [$clog2(TILE_SIZE)-1:0]   neighbor_row        [BANK_COUNT],
    input  logic [$clog2(TILE_SIZE)-1:0]   neighbor_column     [BANK_COUNT],
    input  logic [DATA_WIDTH-1:0]          neighbor_data       [BANK_COUNT],
    input  logic                           neighbor_valid      [BANK_COUNT],
    output logic                           neighbor_ready      [BANK_COUNT],
    output logic [$clog2(TILE_SIZE)-1:0]   buffer_row_write    [BANK_COUNT],
    output logic [$clog2(TILE_SIZE)-1:0]   buffer_column_write [BANK_COUNT],
    output logic [DATA_WIDTH-1:0]          buffer_data_write   [BANK_COUNT],
    output logic                           buffer_write_enable [BANK_COUNT],
    input  logic                           drain_req,
    output logic                           drain_done,
    output logic                           neighbor_pending
`ifdef BANK_WRITE_ARBITER_STATS_EN
    ,
    output logic [15:0]                    conflict_count
`endif
);

    localparam int unsigned ROW_W = $clog2(TILE_SIZE);

    arb_state_e state_q, state_d;
    logic       armed_q;
    logic       local_block;
    logic       any_nvalid;
    logic       any_we;
    logic       pending;

    // Held low for the first cycle after reset release so no stale request is
    // written on the first edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            armed_q <= 1'b0;
        end else begin
            armed_q <= 1'b1;
        end
    end

    assign local_block = (state_q != ST_RUN);

    for (genvar b = 0; b < BANK_COUNT; b++) begin : g_bank
        bank_arb_slice #(
            .ROW_W        (ROW_W),
            .DATA_WIDTH   (DATA_WIDTH),
            .STARVE_LIMIT (STARVE_LIMIT)
        ) u_slice (
            .clk               (clk),
            .reset_n           (reset_n),
            .enable_i          (armed_q),
            .local_block_i     (local_block),
            .local_row_i       (local_row[b]),
            .local_column_i    (local_column[b]),
            .local_data_i      (local_data[b]),
            .local_valid_i     (local_valid[b]),
            .neighbor_row_i    (neighbor_row[b]),
            .neighbor_column_i (neighbor_column[b]),
            .neighbor_data_i   (neighbor_data[b]),
            .neighbor_valid_i  (neighbor_valid[b]),
            .local_ready_o     (local_ready[b]),
            .neighbor_ready_o  (neighbor_ready[b]),
            .buf_row_o         (buffer_row_write[b]),
            .buf_column_o      (buffer_column_write[b]),
            .buf_data_o        (buffer_data_write[b]),
            .buf_we_o          (buffer_write_enable[b])
        );
    end

    always_comb begin
        any_nvalid = 1'b0;
        any_we     = 1'b0;
        pending    = 1'b0;
        for (int unsigned b = 0; b < BANK_COUNT; b++) begin
            any_nvalid = any_nvalid | neighbor_valid[b];
            any_we     = any_we | buffer_write_enable[b];
            pending    = pending | (neighbor_valid[b] & ~neighbor_ready[b]);
        end
    end

    assign neighbor_pending = pending;

    // Drain completes once no neighbor request is waiting and the last accepted
    // write has left the bank ports.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (drain_req) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!drain_req) begin
                    state_d = ST_RUN;
                end else if (!any_nvalid && !any_we) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!drain_req) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    assign drain_done = (state_q == ST_DONE);

`ifdef BANK_WRITE_ARBITER_STATS_EN
    logic [15:0] conflict_q, conflict_d;
    logic        any_conflict;

    always_comb begin
        any_conflict = 1'b0;
        for (int unsigned b = 0; b < BANK_COUNT; b++) begin
            any_conflict = any_conflict | (local_valid[b] & neighbor_valid[b]);
        end
    end

    always_comb begin
        conflict_d = conflict_q;
        if (any_conflict && (conflict_q != 16'hFFFF)) begin
            conflict_d = conflict_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            conflict_q <= 16'd0;
        end else begin
            conflict_q <= conflict_d;
        end
    end

    assign conflict_count = conflict_q;
`endif

endmodule

// File: tb/tb_bank_write_arbiter.sv
// Self-checking bench for bank_write_arbiter. Expected bank writes are queued
// when requests are driven and compared by a monitor when write enables appear.
module tb_bank_write_arbiter;

    localparam int BANKS = 32;
    localparam int TS    = 128;
    localparam int DW    = 16;
    localparam int SL    = 4;
    localparam int RW    = $clog2(TS);

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [RW-1:0] local_row [BANKS];
    logic [RW-1:0] local_column [BANKS];
    logic [DW-1:0] local_data [BANKS];
    logic          local_valid [BANKS];
    logic          local_ready [BANKS];
    logic [RW-1:0] neighbor_row [BANKS];
    logic [RW-1:0] neighbor_column [BANKS];
    logic [DW-1:0] neighbor_data [BANKS];
    logic          neighbor_valid [BANKS];
    logic          neighbor_ready [BANKS];
    logic [RW-1:0] buffer_row_write [BANKS];
    logic [RW-1:0] buffer_column_write [BANKS];
    logic [DW-1:0] buffer_data_write [BANKS];
    logic          buffer_write_enable [BANKS];
    logic          drain_req = 1'b0;
    logic          drain_done;
    logic          neighbor_pending;
`ifdef BANK_WRITE_ARBITER_STATS_EN
    logic [15:0]   conflict_count;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        int            bank;
        logic [RW-1:0] row;
        logic [RW-1:0] col;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    bank_write_arbiter #(
        .BANK_COUNT   (BANKS),
        .TILE_SIZE    (TS),
        .DATA_WIDTH   (DW),
        .STARVE_LIMIT (SL)
    ) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .local_row           (local_row),
        .local_column        (local_column),
        .local_data          (local_data),
        .local_valid         (local_valid),
        .local_ready         (local_ready),
        .neighbor_row        (neighbor_row),
        .neighbor_column     (neighbor_column),
        .neighbor_data       (neighbor_data),
        .neighbor_valid      (neighbor_valid),
        .neighbor_ready      (neighbor_ready),
        .buffer_row_write    (buffer_row_write),
        .buffer_column_write (buffer_column_write),
        .buffer_data_write   (buffer_data_write),
        .buffer_write_enable (buffer_write_enable),
        .drain_req           (drain_req),
        .drain_done          (drain_done),
        .neighbor_pending    (neighbor_pending)
`ifdef BANK_WRITE_ARBITER_STATS_EN
        ,
        .conflict_count      (conflict_count)
`endif
    );

    // Scoreboard monitor: every asserted write enable must match the next queued write.
    always @(negedge clk) begin
        for (int b = 0; b < BANKS; b++) begin
            if (buffer_write_enable[b] === 1'b1) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected_write: bank %0d wrote data %h, expected no write",
                             b, buffer_data_write[b]);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    if (e.bank != b || buffer_row_write[b] !== e.row ||
                        buffer_column_write[b] !== e.col || buffer_data_write[b] !== e.data) begin
                        errors++;
                        $display("FAIL sb_write: got bank %0d row %0d col %0d data %h, expected bank %0d row %0d col %0d data %h",
                                 b, buffer_row_write[b], buffer_column_write[b], buffer_data_write[b],
                                 e.bank, e.row, e.col, e.data);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs();
        for (int b = 0; b < BANKS; b++) begin
            local_row[b] = '0; local_column[b] = '0; local_data[b] = '0; local_valid[b] = 1'b0;
            neighbor_row[b] = '0; neighbor_column[b] = '0; neighbor_data[b] = '0;
            neighbor_valid[b] = 1'b0;
        end
    endtask

    task automatic set_local(input int b, input logic [RW-1:0] r, input logic [RW-1:0] c,
                             input logic [DW-1:0] d);
        local_row[b] = r; local_column[b] = c; local_data[b] = d; local_valid[b] = 1'b1;
    endtask

    task automatic set_neighbor(input int b, input logic [RW-1:0] r, input logic [RW-1:0] c,
                                input logic [DW-1:0] d);
        neighbor_row[b] = r; neighbor_column[b] = c; neighbor_data[b] = d;
        neighbor_valid[b] = 1'b1;
    endtask

    task automatic push_exp(input int b, input logic [RW-1:0] r, input logic [RW-1:0] c,
                            input logic [DW-1:0] d);
        exp_t e;
        e.bank = b; e.row = r; e.col = c; e.data = d;
        sb_q.push_back(e);
    endtask

    function automatic logic any_local_ready();
        logic acc = 1'b0;
        for (int b = 0; b < BANKS; b++) acc |= local_ready[b];
        return acc;
    endfunction

    function automatic logic all_local_ready();
        logic acc = 1'b1;
        for (int b = 0; b < BANKS; b++) acc &= local_ready[b];
        return acc;
    endfunction

    task automatic test_reset();
        logic          any_we;
        logic [DW-1:0] acc;
        clear_inputs();
        reset_n   = 1'b0;
        drain_req = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        any_we = 1'b0;
        acc    = '0;
        for (int b = 0; b < BANKS; b++) begin
            any_we |= buffer_write_enable[b];
            acc    |= buffer_data_write[b] | DW'(buffer_row_write[b]) | DW'(buffer_column_write[b]);
        end
        checks++;
        if (any_we !== 1'b0) begin
            errors++; $display("FAIL reset_we: got %b expected 0", any_we);
        end
        checks++;
        if (acc !== '0) begin
            errors++; $display("FAIL reset_buffer_fields: got %h expected 0", acc);
        end
        checks++;
        if (drain_done !== 1'b0) begin
            errors++; $display("FAIL reset_drain_done: got %b expected 0", drain_done);
        end
`ifdef BANK_WRITE_ARBITER_STATS_EN
        checks++;
        if (conflict_count !== 16'd0) begin
            errors++; $display("FAIL reset_conflict_count: got %0d expected 0", conflict_count);
        end
`endif
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // Bank 0 conflicts in cycles 0..2, bank 4 in cycles 2..3: four distinct cycles.
    task automatic test_stats_conflicts();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            clear_inputs();
            if (c < 3) begin
                set_local(0, RW'(c), 7'd1, DW'(16'h0100 + c));
                set_neighbor(0, 7'd9, 7'd9, DW'(16'h0900 + c));
            end
            if (c >= 2) begin
                set_local(4, RW'(c), 7'd4, DW'(16'h0400 + c));
                set_neighbor(4, 7'd8, 7'd8, DW'(16'h0800 + c));
            end
            #1;
            checks++;
            if (local_ready[0] !== (c < 3) || neighbor_ready[0] !== 1'b0) begin
                errors++;
                $display("FAIL stats_grant_bank0: got local %b neighbor %b expected local %b neighbor 0",
                         local_ready[0], neighbor_ready[0], c < 3);
            end
            if (c < 3) push_exp(0, RW'(c), 7'd1, DW'(16'h0100 + c));
            if (c >= 2) push_exp(4, RW'(c), 7'd4, DW'(16'h0400 + c));
        end
        @(negedge clk);
        clear_inputs();
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++; $display("FAIL stats_sb_drained: got %0d pending expected 0", sb_q.size());
        end
`ifdef BANK_WRITE_ARBITER_STATS_EN
        checks++;
        if (conflict_count !== 16'd4) begin
            errors++; $display("FAIL conflict_count: got %0d expected 4", conflict_count);
        end
`endif
    endtask

    task automatic test_local_only();
        @(negedge clk);
        clear_inputs();
        set_local(5, 7'd3, 7'd7, 16'hABCD);
        #1;
        checks++;
        if (local_ready[5] !== 1'b1 || neighbor_ready[5] !== 1'b0) begin
            errors++;
            $display("FAIL local_only_ready: got local %b neighbor %b expected 1 0",
                     local_ready[5], neighbor_ready[5]);
        end
        checks++;
        if (neighbor_pending !== 1'b0) begin
            errors++; $display("FAIL local_only_pending: got %b expected 0", neighbor_pending);
        end
        push_exp(5, 7'd3, 7'd7, 16'hABCD);
        @(negedge clk);
        clear_inputs();
        @(negedge clk);
        #1;
        checks++;
        if (buffer_write_enable[5] !== 1'b0 || buffer_row_write[5] !== 7'd3 ||
            buffer_column_write[5] !== 7'd7 || buffer_data_write[5] !== 16'hABCD) begin
            errors++;
            $display("FAIL idle_hold: got we %b row %0d col %0d data %h expected we 0 row 3 col 7 data abcd",
                     buffer_write_enable[5], buffer_row_write[5], buffer_column_write[5],
                     buffer_data_write[5]);
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++; $display("FAIL local_only_sb_drained: got %0d pending expected 0", sb_q.size());
        end
    endtask

    // Bank 2 in continuous conflict: local wins four times, then neighbor once.
    task automatic test_starvation();
        logic nw;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            clear_inputs();
            set_local(2, RW'(c), RW'(c + 1), DW'(16'h2000 + c));
            set_neighbor(2, RW'(7'h40 + c), 7'h50, DW'(16'h5000 + c));
            set_neighbor(7, 7'd1, 7'd2, DW'(16'h7000 + c));
            nw = (c == SL);
            #1;
            checks++;
            if (local_ready[2] !== !nw || neighbor_ready[2] !== nw) begin
                errors++;
                $display("FAIL starve_cycle%0d: got local %b neighbor %b expected local %b neighbor %b",
                         c, local_ready[2], neighbor_ready[2], !nw, nw);
            end
            checks++;
            if (neighbor_ready[7] !== 1'b1 || neighbor_pending !== !nw) begin
                errors++;
                $display("FAIL starve_side_cycle%0d: got ready7 %b pending %b expected 1 %b",
                         c, neighbor_ready[7], neighbor_pending, !nw);
            end
            if (nw) push_exp(2, RW'(7'h40 + c), 7'h50, DW'(16'h5000 + c));
            else    push_exp(2, RW'(c), RW'(c + 1), DW'(16'h2000 + c));
            push_exp(7, 7'd1, 7'd2, DW'(16'h7000 + c));
        end
        @(negedge clk);
        clear_inputs();
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++; $display("FAIL starve_sb_drained: got %0d pending expected 0", sb_q.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [RW-1:0] r;
        logic [DW-1:0] d;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            clear_inputs();
            for (int b = 0; b < BANKS; b++) begin
                r = RW'($urandom_range(0, TS - 1));
                d = DW'($urandom);
                set_local(b, r, RW'(b), d);
                push_exp(b, r, RW'(b), d);
            end
            #1;
            checks++;
            if (all_local_ready() !== 1'b1) begin
                errors++; $display("FAIL b2b_all_ready_cycle%0d: got 0 expected 1", c);
            end
        end
        @(negedge clk);
        clear_inputs();
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++; $display("FAIL b2b_sb_drained: got %0d pending expected 0", sb_q.size());
        end
    endtask

    task automatic test_drain();
        @(negedge clk);
        clear_inputs();
        drain_req = 1'b1;
        #1;
        checks++;
        if (drain_done !== 1'b0) begin
            errors++; $display("FAIL drain_enter_done: got %b expected 0", drain_done);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            clear_inputs();
            for (int b = 0; b < BANKS; b++) set_local(b, 7'd1, 7'd1, 16'hEEEE);
            if (c < 2) begin
                set_neighbor(0, RW'(10 + c), 7'd20, DW'(16'hD000 + c));
                set_neighbor(9, RW'(30 + c), 7'd40, DW'(16'hD900 + c));
            end
            #1;
            checks++;
            if (any_local_ready() !== 1'b0) begin
                errors++; $display("FAIL drain_local_blocked_cycle%0d: got 1 expected 0", c);
            end
            checks++;
            if (drain_done !== (c == 4)) begin
                errors++;
                $display("FAIL drain_done_cycle%0d: got %b expected %b", c, drain_done, c == 4);
            end
            if (c < 2) begin
                checks++;
                if (neighbor_ready[0] !== 1'b1 || neighbor_ready[9] !== 1'b1) begin
                    errors++;
                    $display("FAIL drain_neighbor_ready_cycle%0d: got %b %b expected 1 1",
                             c, neighbor_ready[0], neighbor_ready[9]);
                end
                push_exp(0, RW'(10 + c), 7'd20, DW'(16'hD000 + c));
                push_exp(9, RW'(30 + c), 7'd40, DW'(16'hD900 + c));
            end
        end
    endtask

    // Continues from DONE with local requests still asserted on every bank.
    task automatic test_done_exit();
        @(negedge clk);
        drain_req = 1'b0;
        #1;
        checks++;
        if (drain_done !== 1'b1 || any_local_ready() !== 1'b0) begin
            errors++;
            $display("FAIL done_hold: got done %b local %b expected done 1 local 0",
                     drain_done, any_local_ready());
        end
        @(negedge clk);
        for (int b = 0; b < BANKS; b++) set_local(b, RW'(b), 7'd99, DW'(16'hC000 + b));
        #1;
        checks++;
        if (drain_done !== 1'b0 || all_local_ready() !== 1'b1) begin
            errors++;
            $display("FAIL done_exit_run: got done %b all_local %b expected done 0 all_local 1",
                     drain_done, all_local_ready());
        end
        for (int b = 0; b < BANKS; b++) push_exp(b, RW'(b), 7'd99, DW'(16'hC000 + b));
        @(negedge clk);
        clear_inputs();
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++; $display("FAIL drain_sb_drained: got %0d pending expected 0", sb_q.size());
        end
    endtask

    task automatic test_drain_abort();
        @(negedge clk);
        clear_inputs();
        drain_req = 1'b1;
        set_neighbor(3, 7'd5, 7'd6, 16'h3333);
        #1;
        checks++;
        if (neighbor_ready[3] !== 1'b1) begin
            errors++; $display("FAIL abort_run_grant: got %b expected 1", neighbor_ready[3]);
        end
        push_exp(3, 7'd5, 7'd6, 16'h3333);
        @(negedge clk);
        drain_req = 1'b0;
        set_neighbor(3, 7'd5, 7'd6, 16'h3334);
        #1;
        checks++;
        if (neighbor_ready[3] !== 1'b1 || drain_done !== 1'b0) begin
            errors++;
            $display("FAIL abort_drain: got ready %b done %b expected 1 0",
                     neighbor_ready[3], drain_done);
        end
        push_exp(3, 7'd5, 7'd6, 16'h3334);
        @(negedge clk);
        clear_inputs();
        set_local(3, 7'd8, 7'd9, 16'h3335);
        #1;
        checks++;
        if (local_ready[3] !== 1'b1 || drain_done !== 1'b0) begin
            errors++;
            $display("FAIL abort_back_to_run: got local %b done %b expected 1 0",
                     local_ready[3], drain_done);
        end
        push_exp(3, 7'd8, 7'd9, 16'h3335);
        @(negedge clk);
        clear_inputs();
        #1;
        checks++;
        if (sb_q.size() != 0 || drain_done !== 1'b0) begin
            errors++;
            $display("FAIL abort_sb_drained: got %0d pending done %b expected 0 0",
                     sb_q.size(), drain_done);
        end
    endtask

    // Builds bank 1 starvation to 3, resets with a write in flight, then shows the
    // counter restarted from 0 (four local wins before the neighbor gets through).
    task automatic test_reset_mid();
        logic nw;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            clear_inputs();
            set_local(1, RW'(c), 7'd11, DW'(16'h1100 + c));
            set_neighbor(1, 7'd12, 7'd13, DW'(16'h1900 + c));
            #1;
            checks++;
            if (local_ready[1] !== 1'b1) begin
                errors++; $display("FAIL pre_reset_grant_cycle%0d: got %b expected 1", c, local_ready[1]);
            end
            if (c < 2) push_exp(1, RW'(c), 7'd11, DW'(16'h1100 + c));
        end
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        checks++;
        if (buffer_write_enable[1] !== 1'b0) begin
            errors++; $display("FAIL reset_discard_inflight: got %b expected 0", buffer_write_enable[1]);
        end
        @(negedge clk);
        clear_inputs();
        set_local(1, 7'd2, 7'd2, 16'h1E1E);
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            clear_inputs();
            set_local(1, RW'(c), 7'd21, DW'(16'h1A00 + c));
            set_neighbor(1, RW'(c), 7'd22, DW'(16'h1B00 + c));
            nw = (c == SL);
            #1;
            if (c == 0) begin
                checks++;
                if (buffer_write_enable[1] !== 1'b0 || drain_done !== 1'b0) begin
                    errors++;
                    $display("FAIL release_first_edge: got we %b done %b expected 0 0",
                             buffer_write_enable[1], drain_done);
                end
            end
            checks++;
            if (local_ready[1] !== !nw || neighbor_ready[1] !== nw) begin
                errors++;
                $display("FAIL post_reset_starve_cycle%0d: got local %b neighbor %b expected %b %b",
                         c, local_ready[1], neighbor_ready[1], !nw, nw);
            end
            if (nw) push_exp(1, RW'(c), 7'd22, DW'(16'h1B00 + c));
            else    push_exp(1, RW'(c), 7'd21, DW'(16'h1A00 + c));
        end
        @(negedge clk);
        clear_inputs();
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++; $display("FAIL reset_mid_sb_drained: got %0d pending expected 0", sb_q.size());
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_stats_conflicts();
        test_local_only();
        test_starvation();
        test_back_to_back();
        test_drain();
        test_done_exit();
        test_drain_abort();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
